// File: rtl/up_regs_pkg.sv
// Shared register map, bit positions and widths for the copy-engine APB register file.
package up_regs_pkg;

    // Word index of each register, decoded from PADDR[4:2]; index 7 is unmapped.
    typedef enum logic [2:0] {
        UP_REG_SRC      = 3'd0,
        UP_REG_DST      = 3'd1,
        UP_REG_SIZE     = 3'd2,
        UP_REG_CTRL     = 3'd3,
        UP_REG_CMD      = 3'd4,
        UP_REG_STATUS   = 3'd5,
        UP_REG_DONE_CNT = 3'd6
    } up_reg_e;

    localparam int CMD_TRIGGER_BIT     = 0;
    localparam int CMD_CLR_INT_BIT     = 1;
    localparam int STATUS_BUSY_BIT     = 0;
    localparam int STATUS_INT_PEND_BIT = 1;
    localparam int STATUS_LAUNCH_BIT   = 2;
    localparam int CTRL_INT_EN_BIT     = 0;

    localparam int DONE_CNT_WIDTH = 16;
    localparam logic [DONE_CNT_WIDTH-1:0] DONE_CNT_MAX = '1;

    // Transfer parameters that must not move while a copy is running.
    function automatic logic is_busy_locked(input up_reg_e reg_sel);
        return reg_sel inside {UP_REG_SRC, UP_REG_DST, UP_REG_SIZE};
    endfunction

endpackage

// File: rtl/apb_up_regs.sv
// APB register file feeding the AXI copy controller: transfer setup, command
// pulses, status readback and a saturating completed-transfer counter.
module apb_up_regs
    import up_regs_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int REG_SIZE_WIDTH = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [AXI_ADDR_WIDTH-1:0] src_addr_o,
    output logic [AXI_ADDR_WIDTH-1:0] dst_addr_o,
    output logic [REG_SIZE_WIDTH-1:0] size_o,
    output logic                      ctrl_int_en_o,
    output logic                      cmd_trigger_pulse_o,
    output logic                      cmd_clr_int_pulse_o,
    input  logic                      status_busy_i,
    input  logic                      status_int_pending_i
);

    logic access;
    logic wr_en;
    logic rd_en;
    logic addr_valid;
    logic eff_busy;
    logic size_nonzero;
    logic busy_fall;
    up_reg_e reg_sel;

    logic [AXI_ADDR_WIDTH-1:0] src_q, src_d;
    logic [AXI_ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [REG_SIZE_WIDTH-1:0] size_q, size_d;
    logic                      int_en_q, int_en_d;
    logic                      r_launch_q, r_launch_d;
    logic                      r_busy_q, r_busy_d;
    logic [DONE_CNT_WIDTH-1:0] done_cnt_q, done_cnt_d;
    logic                      trig_q, trig_d;
    logic                      clr_q, clr_d;

    // Address bits outside the word decode and write-data bits above the
    // register widths are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0], PWDATA};

    assign access       = PSEL & PENABLE;
    assign wr_en        = access & PWRITE;
    assign rd_en        = access & ~PWRITE;
    assign reg_sel      = up_reg_e'(PADDR[4:2]);
    assign addr_valid   = (PADDR[4:2] <= 3'(UP_REG_DONE_CNT));
    // The launch flag covers the cycle between the trigger pulse and the
    // controller raising its own busy.
    assign eff_busy     = status_busy_i | r_launch_q;
    assign size_nonzero = (size_q != '0);
    assign busy_fall    = r_busy_q & ~status_busy_i;

    // Next-state for all registers: APB writes, command pulses, launch flag, done counter.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        src_d      = src_q;
        dst_d      = dst_q;
        size_d     = size_q;
        int_en_d   = int_en_q;
        done_cnt_d = done_cnt_q;
        trig_d     = 1'b0;
        clr_d      = 1'b0;
        r_busy_d   = status_busy_i;

        if (wr_en) begin
            case (reg_sel)
                UP_REG_SRC:  if (!eff_busy) src_d = PWDATA[AXI_ADDR_WIDTH-1:0];
                UP_REG_DST:  if (!eff_busy) dst_d = PWDATA[AXI_ADDR_WIDTH-1:0];
                UP_REG_SIZE: if (!eff_busy) size_d = {PWDATA[REG_SIZE_WIDTH-1:2], 2'b00};
                UP_REG_CTRL: int_en_d = PWDATA[CTRL_INT_EN_BIT];
                UP_REG_CMD: begin
                    trig_d = PWDATA[CMD_TRIGGER_BIT] & ~eff_busy & size_nonzero;
                    clr_d  = PWDATA[CMD_CLR_INT_BIT];
                end
                default: ;
            endcase
        end

        // An accepted trigger can only happen while status_busy_i is low,
        // so set and clear never compete.
        r_launch_d = r_launch_q;
        if (trig_d) begin
            r_launch_d = 1'b1;
        end else if (status_busy_i) begin
            r_launch_d = 1'b0;
        end

        // A clear that coincides with a completion still counts that completion.
        if (wr_en && reg_sel == UP_REG_DONE_CNT) begin
            done_cnt_d = busy_fall ? DONE_CNT_WIDTH'(1) : '0;
        end else if (busy_fall && done_cnt_q != DONE_CNT_MAX) begin
            done_cnt_d = done_cnt_q + DONE_CNT_WIDTH'(1);
        end
    end

    // Register state with synchronous active-low reset; drops any pending pulse.
    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!ARESETn) begin
            src_q      <= '0;
            dst_q      <= '0;
            size_q     <= '0;
            int_en_q   <= 1'b0;
            r_launch_q <= 1'b0;
            r_busy_q   <= 1'b0;
            done_cnt_q <= '0;
            trig_q     <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            src_q      <= src_d;
            dst_q      <= dst_d;
            size_q     <= size_d;
            int_en_q   <= int_en_d;
            r_launch_q <= r_launch_d;
            r_busy_q   <= r_busy_d;
            done_cnt_q <= done_cnt_d;
            trig_q     <= trig_d;
            clr_q      <= clr_d;
        end
    end

    // Read data mux, driven only during a read access.
    always_comb begin
        PRDATA = '0;
        if (rd_en) begin
            case (reg_sel)
                UP_REG_SRC:  PRDATA = 32'(src_q);
                UP_REG_DST:  PRDATA = 32'(dst_q);
                UP_REG_SIZE: PRDATA = 32'(size_q);
                UP_REG_CTRL: PRDATA[CTRL_INT_EN_BIT] = int_en_q;
                UP_REG_STATUS: begin
                    PRDATA[STATUS_BUSY_BIT]     = eff_busy;
                    PRDATA[STATUS_INT_PEND_BIT] = status_int_pending_i;
                    PRDATA[STATUS_LAUNCH_BIT]   = r_launch_q;
                end
                UP_REG_DONE_CNT: PRDATA = 32'(done_cnt_q);
                default: ;
            endcase
        end
    end

    // Error response: unmapped offset, locked setup write, or refused trigger.
    always_comb begin
        PSLVERR = 1'b0;
        if (access) begin
            if (!addr_valid) begin
                PSLVERR = 1'b1;
            end else if (PWRITE) begin
                if (is_busy_locked(reg_sel)) begin
                    PSLVERR = eff_busy;
                end else if (reg_sel == UP_REG_CMD) begin
                    PSLVERR = PWDATA[CMD_TRIGGER_BIT] & (eff_busy | ~size_nonzero);
                end
            end
        end
    end

    assign PREADY              = 1'b1;
    assign src_addr_o          = src_q;
    assign dst_addr_o          = dst_q;
    assign size_o              = size_q;
    assign ctrl_int_en_o       = int_en_q;
    assign cmd_trigger_pulse_o = trig_q;
    assign cmd_clr_int_pulse_o = clr_q;

endmodule

// File: tb/tb_apb_up_regs.sv
// Scoreboard bench for apb_up_regs: the driver pushes the expected APB response
// from a behavioural model, a negedge monitor pops and compares it and checks
// the register outputs every cycle.
module tb_apb_up_regs;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] src_addr_o, dst_addr_o;
    logic [15:0] size_o;
    logic        ctrl_int_en_o, cmd_trigger_pulse_o, cmd_clr_int_pulse_o;
    logic        status_busy_i, status_int_pending_i;

    always #5 ACLK = ~ACLK;

    apb_up_regs #(.APB_ADDR_WIDTH(12), .AXI_ADDR_WIDTH(32), .REG_SIZE_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .size_o(size_o),
        .ctrl_int_en_o(ctrl_int_en_o),
        .cmd_trigger_pulse_o(cmd_trigger_pulse_o), .cmd_clr_int_pulse_o(cmd_clr_int_pulse_o),
        .status_busy_i(status_busy_i), .status_int_pending_i(status_int_pending_i)
    );

    localparam logic [11:0] A_SRC = 12'h00, A_DST = 12'h04, A_SIZE = 12'h08, A_CTRL = 12'h0C,
                            A_CMD = 12'h10, A_STAT = 12'h14, A_DONE = 12'h18, A_BAD = 12'h1C;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_src, m_dst;
    logic [15:0] m_size;
    bit          m_int_en, m_launch, m_busy_prev, m_trig, m_clr;
    int          m_done;
    bit          mdl_eff, mdl_wr, mdl_fall;
    int          mdl_idx;

    // State the registers hold after each clock edge, from the inputs seen in the finished cycle.
    always @(posedge ACLK) begin
        if (!ARESETn) begin
            m_src = 0; m_dst = 0; m_size = 0; m_int_en = 0; m_launch = 0;
            m_busy_prev = 0; m_trig = 0; m_clr = 0; m_done = 0;
        end else begin
            mdl_eff  = status_busy_i || m_launch;
            mdl_wr   = PSEL && PENABLE && PWRITE;
            mdl_idx  = int'(PADDR[4:2]);
            mdl_fall = m_busy_prev && !status_busy_i;
            m_trig = 0;
            m_clr  = 0;
            if (mdl_wr) begin
                case (mdl_idx)
                    0: if (!mdl_eff) m_src = PWDATA;
                    1: if (!mdl_eff) m_dst = PWDATA;
                    2: if (!mdl_eff) m_size = PWDATA[15:0] & 16'hFFFC;
                    3: m_int_en = PWDATA[0];
                    4: begin
                        m_trig = PWDATA[0] && !mdl_eff && (m_size != 0);
                        m_clr  = PWDATA[1];
                    end
                    default: ;
                endcase
            end
            if (m_trig) m_launch = 1;
            else if (status_busy_i) m_launch = 0;
            if (mdl_wr && mdl_idx == 6) m_done = mdl_fall ? 1 : 0;
            else if (mdl_fall) m_done = (m_done >= 65535) ? 65535 : m_done + 1;
            m_busy_prev = status_busy_i;
        end
    end

    typedef struct {
        string       name;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- driver ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    // One APB transfer; busy_acc >= 0 overrides status_busy_i for the access cycle.
    task automatic apb(input logic [11:0] addr, input bit wr, input logic [31:0] data,
                       input int busy_acc = -1);
        exp_t e;
        bit   eff;
        int   idx;
        PSEL = 1; PENABLE = 0; PADDR = addr; PWRITE = wr; PWDATA = data;
        @(posedge ACLK);
        #1;
        PENABLE = 1;
        if (busy_acc >= 0) status_busy_i = (busy_acc != 0);
        eff = status_busy_i || m_launch;
        idx = int'(addr[4:2]);
        e.name  = $sformatf("%s@%03h", wr ? "wr" : "rd", addr);
        e.rdata = 0;
        e.err   = 0;
        if (idx == 7) e.err = 1;
        else if (wr) begin
            if (idx <= 2) e.err = eff;
            else if (idx == 4) e.err = data[0] && (eff || m_size == 0);
        end else begin
            case (idx)
                0: e.rdata = m_src;
                1: e.rdata = m_dst;
                2: e.rdata = {16'h0, m_size};
                3: e.rdata = {31'h0, m_int_en};
                5: e.rdata = {29'h0, m_launch, status_int_pending_i, eff};
                6: e.rdata = m_done;
                default: e.rdata = 0;
            endcase
        end
        exp_q.push_back(e);
        @(posedge ACLK);
        #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge ACLK) begin
        exp_t e;
        if (mon_en) begin
            if (PSEL && PENABLE && PREADY) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard: access completed with no expected entry at t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, " prdata"}, PRDATA, e.rdata);
                    check({e.name, " pslverr"}, 32'(PSLVERR), 32'(e.err));
                end
            end else begin
                check("idle pslverr", 32'(PSLVERR), 0);
                check("idle prdata", PRDATA, 0);
            end
            check("pready", 32'(PREADY), 1);
            check("src_addr_o", src_addr_o, m_src);
            check("dst_addr_o", dst_addr_o, m_dst);
            check("size_o", 32'(size_o), 32'(m_size));
            check("ctrl_int_en_o", 32'(ctrl_int_en_o), 32'(m_int_en));
            check("trigger pulse", 32'(cmd_trigger_pulse_o), 32'(m_trig));
            check("clr_int pulse", 32'(cmd_clr_int_pulse_o), 32'(m_clr));
        end
    end

    // Time bound on the whole run.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [11:0] addr;
        logic [31:0] data;
        bit          wr;
        int          idx;

        ARESETn = 0; PADDR = 0; PWDATA = 0; PWRITE = 0; PSEL = 0; PENABLE = 0;
        status_busy_i = 0; status_int_pending_i = 0;
        @(posedge ACLK);
        #1;
        mon_en = 1;
        cycles(2);
        ARESETn = 1;
        cycles(1);

        // Reset values across the whole map, plus the unmapped offset.
        for (int a = 0; a < 8; a++) apb(12'(a * 4), 0, 0);

        // Transfer setup; SIZE low bits dropped.
        apb(A_SRC, 1, 32'h1000_0000);
        apb(A_DST, 1, 32'h1000_1000);
        apb(A_SIZE, 1, 32'h13);
        apb(A_SIZE, 0, 0);

        // Trigger while idle, launch flag visible until busy rises.
        apb(A_CMD, 1, 32'h1);
        apb(A_STAT, 0, 0);
        status_busy_i = 1;
        cycles(1);
        apb(A_STAT, 0, 0);

        // Refused writes while busy.
        apb(A_CMD, 1, 32'h1);
        apb(A_SRC, 1, 32'hDEAD_BEEF);
        apb(A_SRC, 0, 0);
        status_busy_i = 0;
        cycles(1);

        // Trigger with SIZE = 0 while idle is refused.
        apb(A_SIZE, 1, 32'h0);
        apb(A_CMD, 1, 32'h1);

        // Two more completions, then clear coinciding with a completion.
        repeat (2) begin
            status_busy_i = 1; cycles(1);
            status_busy_i = 0; cycles(1);
        end
        apb(A_DONE, 0, 0);
        status_busy_i = 1;
        apb(A_DONE, 1, 32'hFFFF, 0);
        apb(A_DONE, 0, 0);

        // Both command bits at once, then interrupt enable and pending status.
        apb(A_SIZE, 1, 32'h40);
        apb(A_CMD, 1, 32'h3);
        status_busy_i = 1; cycles(1);
        status_busy_i = 0; cycles(1);
        apb(A_CTRL, 1, 32'h1);
        status_int_pending_i = 1;
        apb(A_STAT, 0, 0);
        apb(A_CMD, 1, 32'h2);

        // Reset in the middle of a launch clears everything.
        apb(A_SRC, 1, 32'h55);
        apb(A_CMD, 1, 32'h1);
        ARESETn = 0;
        cycles(2);
        ARESETn = 1;
        status_int_pending_i = 0;
        cycles(1);
        for (int a = 0; a < 7; a++) apb(12'(a * 4), 0, 0);

        // Randomized traffic with a wandering controller.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) status_busy_i = ~status_busy_i;
            if ($urandom_range(0, 7) == 0) status_int_pending_i = ~status_int_pending_i;
            idx  = $urandom_range(0, 7);
            addr = 12'(idx * 4 + $urandom_range(0, 3));
            wr   = bit'($urandom_range(0, 1));
            data = $urandom;
            if (idx == 2) data = 32'($urandom_range(0, 64));
            if (idx == 4) data = 32'($urandom_range(0, 3));
            apb(addr, wr, data);
            if ($urandom_range(0, 4) == 0) cycles(1);
        end

        status_busy_i = 0;
        cycles(3);
        check("scoreboard drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_up_regs.md
Name: apb_up_regs

Overview:
- APB slave register file for the user-plugin copy engine; sits directly upstream of the AXI copy controller.
- Holds the source address, destination address, byte size and interrupt enable, and drives them to the controller.
- Turns APB writes to a command register into single-cycle trigger and clear-interrupt pulses.
- Reads back controller status and keeps a saturating count of completed transfers.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR.
- AXI_ADDR_WIDTH, 32, width of the src/dst address outputs; must be 32 or less.
- REG_SIZE_WIDTH, 16, width of the size output, in bytes.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset; synchronous, active-low.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB direction (1 = write).
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready; tied to 1.
- PSLVERR  out  1  APB error response.
- src_addr_o  out  AXI_ADDR_WIDTH  copy source byte address.
- dst_addr_o  out  AXI_ADDR_WIDTH  copy destination byte address.
- size_o  out  REG_SIZE_WIDTH  copy size in bytes; bits [1:0] always 0.
- ctrl_int_en_o  out  1  interrupt enable.
- cmd_trigger_pulse_o  out  1  one-cycle start command.
- cmd_clr_int_pulse_o  out  1  one-cycle interrupt-pending clear.
- status_busy_i  in  1  controller busy.
- status_int_pending_i  in  1  controller interrupt pending.

Behaviour:
- Reset (ARESETn low at a rising edge of ACLK):
  - all registers and outputs go to 0; PRDATA = 0; PSLVERR = 0;
  - r_launch = 0; r_busy_q = 0; DONE_CNT = 0.
- Access phase is PSEL & PENABLE; PREADY = 1, so every access completes in that cycle.
- Address decode uses PADDR[4:2]. Register map (word offsets):
  - 0x00 SRC: RW.
  - 0x04 DST: RW.
  - 0x08 SIZE: RW; bits [1:0] write-ignored and read 0.
  - 0x0C CTRL: RW; bit0 = int_en.
  - 0x10 CMD: WO, reads 0; bit0 = trigger, bit1 = clr_int.
  - 0x14 STATUS: RO; bit0 = effective busy, bit1 = int_pending, bit2 = r_launch.
  - 0x18 DONE_CNT: RW; bits [15:0]; any write clears it.
  - Offsets above 0x18: read 0, PSLVERR = 1, writes have no effect.
- Effective busy: eff_busy = status_busy_i | r_launch.
  - r_launch is set with the cycle that asserts cmd_trigger_pulse_o.
  - r_launch clears on the first cycle status_busy_i = 1.
  - This closes the one-cycle window in which the controller has not yet raised busy.
- Writes to SRC/DST/SIZE while eff_busy = 1:
  - register is not updated; PSLVERR = 1 in the access cycle.
  - CTRL is writable at any time.
- CMD write:
  - Pulses are registered and asserted exactly one cycle after the access cycle, high for one cycle.
  - trigger is accepted only if eff_busy = 0 and SIZE != 0. Otherwise no pulse and PSLVERR = 1.
  - clr_int is always accepted.
  - Both bits set: both pulses fire in the same cycle, subject to the trigger rule.
- SRC/DST/SIZE are stable while eff_busy = 1; the controller samples them on the trigger pulse.
- Read data:
  - PRDATA is combinational from the register state during the access cycle.
  - PRDATA = 0 outside read accesses.
  - Unused register bits read 0; SRC/DST are zero-extended to 32 bits.
- Done counter:
  - r_busy_q <= status_busy_i each cycle.
  - On r_busy_q & ~status_busy_i (busy falling edge), DONE_CNT increments, saturating at 0xFFFF.
  - Write-clear in the same cycle as an increment: DONE_CNT = 1.
- PSLVERR is asserted only during an access cycle and is 0 otherwise.
- Mid-operation reset: all state clears. A pulse pending for the next cycle is dropped.

Decomposition:
- Package up_regs_pkg holds:
  - register offset constants: UP_REG_SRC, UP_REG_DST, UP_REG_SIZE, UP_REG_CTRL, UP_REG_CMD, UP_REG_STATUS, UP_REG_DONE_CNT;
  - CMD/STATUS/CTRL bit-index constants;
  - DONE_CNT width.
- No sub-module; edge detect and counter are inline. Total is about 180 lines.

Test Plan:
- Reset, then read all offsets 0x00–0x18 -> all 0, PSLVERR = 0; read 0x1C -> PRDATA 0, PSLVERR = 1.
- Write SRC=0x1000_0000, DST=0x1000_1000, SIZE=0x13 -> outputs show these values with size_o = 0x10; readback SIZE = 0x10.
- Write CMD=0x1 with status_busy_i = 0 -> cmd_trigger_pulse_o high exactly one cycle after the access; STATUS bit2 = 1 until status_busy_i rises.
- Repeat CMD=0x1 and SRC write while busy -> no pulse, PSLVERR = 1, SRC unchanged; CMD=0x1 with SIZE=0 when idle -> PSLVERR = 1, no pulse.
- Drive status_busy_i 1→0 three times -> DONE_CNT reads 3; write DONE_CNT in the same cycle as a falling edge -> reads 1.
- CMD=0x3 when idle with SIZE != 0 -> both pulses in the same cycle; set CTRL=1 and status_int_pending_i = 1 -> STATUS = 0x2, ctrl_int_en_o = 1.
